floor_call_dispatcher: RTL and testbench
========================================

Name: floor_call_dispatcher

Overview:
- Request side of the car controller.
- Collects landing-call button presses and latches them as pending calls.
- Picks the next target floor with SCAN (elevator) ordering and drives it one-hot onto the controller's requested_floor input.
- Watches the controller's present_floor one-hot output to clear served calls and hold a door-dwell period before dispatching again.

Parameters:
- N_FLOORS, 4: number of floors; width of all floor vectors; bit i = floor i.
- DWELL_TICKS, 2: tick pulses held at a served floor before the next dispatch; minimum 1.
- SYNC_STAGES, 2: synchronizer depth on call_btn.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- tick  in  1  one-cycle strobe from the shared one-second timer.
- call_btn  in  N_FLOORS  raw asynchronous call buttons, active-high level.
- present_floor  in  N_FLOORS  one-hot car position from the car controller.
- requested_floor  out  N_FLOORS  one-hot target floor to the car controller.
- pending  out  N_FLOORS  latched unserved calls.
- dir_up  out  1  current sweep direction (1 = up).
- busy  out  1  high in MOVING and DWELL.
- arrived  out  1  one-cycle pulse when a call is served.
- err_floor  out  1  high in any cycle where present_floor is not one-hot.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, rst_n. All flops clear immediately on rst_n low.
- Reset values:
  - pending = 0, requested_floor = 0…01 (floor 0), dir_up = 1.
  - busy = 0, arrived = 0, err_floor = 0.
  - State IDLE, dwell count 0, synchronizer flops 0.
  - Reset mid-operation discards all pending calls; requested_floor returns to floor 0.
- Button capture:
  - call_btn[i] passes through SYNC_STAGES flops, then a rising-edge detect.
  - pending[i] sets on the (SYNC_STAGES+1)th clk edge after call_btn[i] rises.
  - A held button is one call. A press on an already-pending floor has no effect.
- cur = index of present_floor's set bit.
- Target function:
  - Up (dir_up = 1): lowest pending index > cur. If none, the highest pending index < cur, and dir_up flips to 0.
  - Down: mirror of up.
  - Direction updates only on a dispatch or retarget.
- States:
  - IDLE (busy = 0; requested_floor = present_floor):
    - If pending[cur]: clear it, pulse arrived, load dwell count = DWELL_TICKS, go to DWELL.
    - Else if any pending: requested_floor = target one-hot, update dir_up, go to MOVING.
    - Else stay.
  - MOVING (busy = 1):
    - Each cycle, retarget to the nearest pending floor strictly ahead of cur in the current direction, or at cur. This lets a new call en route shorten the trip.
    - When present_floor == requested_floor: clear that pending bit, pulse arrived, load the dwell count, go to DWELL.
  - DWELL (busy = 1; requested_floor = present_floor):
    - Decrement the dwell count on each tick; when it reaches 0, go to IDLE.
    - Presses at cur are ignored (door open). Presses at other floors latch normally.
- Simultaneous set and clear of the same pending bit in one cycle: clear wins.
- present_floor == 0 or multi-hot:
  - err_floor = 1 that cycle.
  - State, pending, requested_floor and dir_up hold; no clear, no arrived pulse.
  - Button capture continues.
- arrived is never high in two consecutive cycles.
- requested_floor is always exactly one-hot.

Test Plan:
- Reset: hold rst_n low, then release -> requested_floor = 4'b0001, pending = 0, busy = 0, dir_up = 1, arrived = 0. Assert rst_n low mid-MOVING -> all outputs return to reset values without waiting for a clk edge.
- Single call: car at floor 0, pulse call_btn[2] -> pending = 4'b0100 on the 3rd edge; next edge requested_floor = 4'b0100, busy = 1. Model the car stepping 0010, then 0100 on ticks -> one arrived pulse, pending = 0, 2 ticks of DWELL, then busy = 0.
- SCAN order: car at floor 1, dir_up = 1, pending = 4'b1001 -> requested 4'b1000 first (dir_up stays 1). After the DWELL there, requested 4'b0001 with dir_up = 0.
- En-route pickup: MOVING 0->3, car at floor 1, press call_btn[2] -> requested_floor changes to 4'b0100; car stops at 2 (arrived), then continues to 3.
- Current-floor press: in DWELL at floor 2, press call_btn[2] -> pending stays 0. In IDLE at floor 2, press call_btn[2] -> arrived pulse, DWELL entered, requested_floor stays 4'b0100.
- Bad position: drive present_floor = 4'b0000, then 4'b0011 during MOVING -> err_floor = 1 each cycle; state, pending and requested_floor frozen. Restore a valid one-hot -> normal operation resumes.

Source files
------------

// File: rtl/floor_call_dispatcher.sv
// floor_call_dispatcher: latches landing calls and dispatches the
// next target floor to the car controller using SCAN ordering.
module floor_call_dispatcher #(
   parameter int N_FLOORS    = 4,
   parameter int DWELL_TICKS = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                tick,
   input  logic [N_FLOORS-1:0] call_btn,
   input  logic [N_FLOORS-1:0] present_floor,
   output logic [N_FLOORS-1:0] requested_floor,
   output logic [N_FLOORS-1:0] pending,
   output logic                dir_up,
   output logic                busy,
   output logic                arrived,
   output logic                err_floor
);

   localparam int DW = $clog2(DWELL_TICKS + 1);
   localparam logic [N_FLOORS-1:0] ONE = 1;
   localparam logic [DW-1:0] DW_ONE = 1;
   localparam logic [DW-1:0] DW_LOAD = DW'(DWELL_TICKS);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_MOVING = 2'd1;
   localparam logic [1:0] S_DWELL  = 2'd2;

   logic [N_FLOORS-1:0] sync_q [SYNC_STAGES];
   logic [N_FLOORS-1:0] sync_d [SYNC_STAGES];
   logic [N_FLOORS-1:0] edge_q, edge_d;
   logic [N_FLOORS-1:0] pending_q, pending_d;
   logic [N_FLOORS-1:0] req_q, req_d;
   logic                dir_q, dir_d;
   logic [1:0]          state_q, state_d;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic                arrived_q, arrived_d;

   logic [N_FLOORS-1:0] rise, set_m, clr_m;
   logic                pos_ok;
   int                  cur_i, up_idx, dn_idx;
   logic                up_hit, dn_hit;

   // Button synchronizer chain and rising-edge detect
   always_comb begin
      sync_d[0] = call_btn;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         sync_d[i] = sync_q[i-1];
      end
      edge_d = sync_q[SYNC_STAGES-1];
      rise   = sync_q[SYNC_STAGES-1] & ~edge_q;
   end

   // Decode car position and search pending calls either side of it
   always_comb begin
      pos_ok = (present_floor != '0) &&
               ((present_floor & (present_floor - ONE)) == '0);
      cur_i = 0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (present_floor[i]) cur_i = i;
      end
      up_hit = 1'b0;
      up_idx = 0;
      for (int i = N_FLOORS - 1; i >= 0; i--) begin
         if (pending_q[i] && i > cur_i) begin
            up_hit = 1'b1;
            up_idx = i;
         end
      end
      dn_hit = 1'b0;
      dn_idx = 0;
      for (int i = 0; i < N_FLOORS; i++) begin
         if (pending_q[i] && i < cur_i) begin
            dn_hit = 1'b1;
            dn_idx = i;
         end
      end
   end

   // Dispatch FSM; an invalid position freezes everything but capture
   always_comb begin
      state_d   = state_q;
      req_d     = req_q;
      dir_d     = dir_q;
      dwell_d   = dwell_q;
      arrived_d = 1'b0;
      set_m     = rise;
      clr_m     = '0;
      if (pos_ok) begin
         case (state_q)
            S_IDLE: begin
               req_d = present_floor;
               if ((pending_q & present_floor) != '0) begin
                  clr_m     = present_floor;
                  arrived_d = 1'b1;
                  dwell_d   = DW_LOAD;
                  state_d   = S_DWELL;
               end else if (pending_q != '0) begin
                  state_d = S_MOVING;
                  if (dir_q) begin
                     if (up_hit) begin
                        req_d = ONE << up_idx;
                     end else begin
                        req_d = ONE << dn_idx;
                        dir_d = 1'b0;
                     end
                  end else begin
                     if (dn_hit) begin
                        req_d = ONE << dn_idx;
                     end else begin
                        req_d = ONE << up_idx;
                        dir_d = 1'b1;
                     end
                  end
               end
            end
            S_MOVING: begin
               if (present_floor == req_q) begin
                  clr_m     = present_floor;
                  arrived_d = 1'b1;
                  dwell_d   = DW_LOAD;
                  state_d   = S_DWELL;
               end else if ((pending_q & present_floor) != '0) begin
                  req_d = present_floor;
               end else if (dir_q && up_hit) begin
                  req_d = ONE << up_idx;
               end else if (!dir_q && dn_hit) begin
                  req_d = ONE << dn_idx;
               end
            end
            S_DWELL: begin
               req_d = present_floor;
               set_m = rise & ~present_floor;
               if (tick) begin
                  if (dwell_q <= DW_ONE) begin
                     dwell_d = '0;
                     state_d = S_IDLE;
                  end else begin
                     dwell_d = dwell_q - DW_ONE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
      pending_d = (pending_q | set_m) & ~clr_m;
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         edge_q    <= '0;
         pending_q <= '0;
         req_q     <= ONE;
         dir_q     <= 1'b1;
         state_q   <= S_IDLE;
         dwell_q   <= '0;
         arrived_q <= 1'b0;
      end else begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
         edge_q    <= edge_d;
         pending_q <= pending_d;
         req_q     <= req_d;
         dir_q     <= dir_d;
         state_q   <= state_d;
         dwell_q   <= dwell_d;
         arrived_q <= arrived_d;
      end
   end

   assign requested_floor = req_q;
   assign pending         = pending_q;
   assign dir_up          = dir_q;
   assign busy            = (state_q != S_IDLE);
   assign arrived         = arrived_q;
   assign err_floor       = ~pos_ok;

endmodule

// File: tb/tb_floor_call_dispatcher.sv
// tb_floor_call_dispatcher: table vectors, directed corner cases
// and random traffic against a floor-level reference model.
module tb_floor_call_dispatcher;

   localparam int NF = 4;
   localparam int DT = 2;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          tick = 1'b0;
   logic [NF-1:0] call_btn = '0;
   logic [NF-1:0] present_floor = 4'b0001;
   logic [NF-1:0] requested_floor, pending;
   logic          dir_up, busy, arrived, err_floor;

   int checks = 0;
   int failures = 0;

   floor_call_dispatcher #(
      .N_FLOORS(NF), .DWELL_TICKS(DT), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick),
      .call_btn(call_btn), .present_floor(present_floor),
      .requested_floor(requested_floor), .pending(pending),
      .dir_up(dir_up), .busy(busy), .arrived(arrived),
      .err_floor(err_floor)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   localparam int M_IDLE = 0, M_MOVE = 1, M_DWELL = 2;
   int            m_mode, m_req, m_dwell;
   bit            m_pend [NF];
   bit            m_dir, m_arr, m_err;
   logic [NF-1:0] hist [$];

   task automatic model_reset();
      m_mode = M_IDLE; m_req = 0; m_dwell = 0;
      m_dir = 1; m_arr = 0; m_err = 0;
      for (int i = 0; i < NF; i++) m_pend[i] = 0;
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back('0);
   endtask

   // nearest pending floor beyond cur going up (or down), -1 if none
   function automatic int seek(bit up, int cur);
      if (up) begin
         for (int i = cur + 1; i < NF; i++) if (m_pend[i]) return i;
      end else begin
         for (int i = cur - 1; i >= 0; i--) if (m_pend[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step(input logic [NF-1:0] btn,
                             input logic [NF-1:0] pf,
                             input logic tk);
      bit rise [NF];
      bit clr [NF];
      int cur, n, t;
      n = 0; cur = 0;
      for (int i = 0; i < NF; i++) if (pf[i]) begin n++; cur = i; end
      m_err = (n != 1);
      for (int i = 0; i < NF; i++) begin
         rise[i] = hist[SS-1][i] && !hist[SS][i];
         clr[i] = 0;
      end
      hist.push_front(btn);
      void'(hist.pop_back());
      m_arr = 0;
      if (!m_err) begin
         if (m_mode == M_IDLE) begin
            m_req = cur;
            if (m_pend[cur]) begin
               clr[cur] = 1; m_arr = 1; m_dwell = DT; m_mode = M_DWELL;
            end else begin
               t = seek(m_dir, cur);
               if (t < 0) begin
                  t = seek(!m_dir, cur);
                  if (t >= 0) m_dir = !m_dir;
               end
               if (t >= 0) begin m_req = t; m_mode = M_MOVE; end
            end
         end else if (m_mode == M_MOVE) begin
            if (cur == m_req) begin
               clr[cur] = 1; m_arr = 1; m_dwell = DT; m_mode = M_DWELL;
            end else if (m_pend[cur]) begin
               m_req = cur;
            end else begin
               t = seek(m_dir, cur);
               if (t >= 0) m_req = t;
            end
         end else begin
            m_req = cur;
            rise[cur] = 0;
            if (tk) begin
               m_dwell--;
               if (m_dwell == 0) m_mode = M_IDLE;
            end
         end
      end
      for (int i = 0; i < NF; i++) m_pend[i] = (m_pend[i] || rise[i]) && !clr[i];
   endtask

   function automatic logic [11:0] model_vec();
      logic [NF-1:0] r, p;
      r = 4'b0001 << m_req;
      for (int i = 0; i < NF; i++) p[i] = m_pend[i];
      return {r, p, m_dir, (m_mode != M_IDLE), m_arr, m_err};
   endfunction

   // ---------------- checking helpers ----------------
   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic cyc(input logic [NF-1:0] btn, input logic [NF-1:0] pf,
                      input logic tk);
      call_btn = btn; present_floor = pf; tick = tk;
      @(posedge clk);
      model_step(btn, pf, tk);
      #1;
      chk("cycle_vs_model",
          {requested_floor, pending, dir_up, busy, arrived, err_floor},
          model_vec());
   endtask

   task automatic do_reset(input logic [NF-1:0] pf);
      rst_n = 1'b0; call_btn = '0; tick = 1'b0; present_floor = pf;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state",
          {requested_floor, pending, dir_up, busy, arrived},
          {4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic [NF-1:0] btn;
      logic [NF-1:0] pf;
      logic          tk;
      logic [NF-1:0] req;
      logic [NF-1:0] pend;
      logic          bsy;
      logic          arr;
      logic          dir;
   } vec_t;

   vec_t tbl [11];

   int            car;
   int            tgt;
   logic [NF-1:0] rb, rpf;
   logic          rtk, prev_arr;

   initial begin
      // single call to floor 2 with car starting at floor 0
      tbl[0]  = '{4'b0100, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{4'b0100, 4'b0001, 1'b0, 4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1};
      tbl[2]  = '{4'b0100, 4'b0001, 1'b0, 4'b0001, 4'b0100, 1'b0, 1'b0, 1'b1};
      tbl[3]  = '{4'b0000, 4'b0001, 1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1};
      tbl[4]  = '{4'b0000, 4'b0010, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 1'b1};
      tbl[5]  = '{4'b0000, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{4'b0000, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{4'b0000, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1};
      tbl[8]  = '{4'b0000, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1};
      tbl[9]  = '{4'b0000, 4'b0100, 1'b1, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1};
      tbl[10] = '{4'b0000, 4'b0100, 1'b0, 4'b0100, 4'b0000, 1'b0, 1'b0, 1'b1};

      do_reset(4'b0001);
      for (int i = 0; i < 11; i++) begin
         cyc(tbl[i].btn, tbl[i].pf, tbl[i].tk);
         chk($sformatf("table_row%0d", i),
             {requested_floor, pending, busy, arrived, dir_up},
             {tbl[i].req, tbl[i].pend, tbl[i].bsy, tbl[i].arr, tbl[i].dir});
      end

      // current-floor press in IDLE, then in DWELL
      cyc(4'b0100, 4'b0100, 1'b0);
      cyc(4'b0000, 4'b0100, 1'b0);
      cyc(4'b0000, 4'b0100, 1'b0);
      chk("idle_press_latched", pending, 4'b0100);
      cyc(4'b0000, 4'b0100, 1'b0);
      chk("idle_press_served", {arrived, busy, requested_floor, pending},
          {1'b1, 1'b1, 4'b0100, 4'b0000});
      cyc(4'b0100, 4'b0100, 1'b0);
      repeat (3) cyc(4'b0000, 4'b0100, 1'b0);
      chk("dwell_press_ignored", {pending, busy}, {4'b0000, 1'b1});
      cyc(4'b0000, 4'b0100, 1'b1);
      cyc(4'b0000, 4'b0100, 1'b1);
      chk("dwell_done", busy, 1'b0);

      // SCAN ordering from floor 1 with calls at 0 and 3
      do_reset(4'b0010);
      cyc(4'b1001, 4'b0010, 1'b0);
      cyc(4'b0000, 4'b0010, 1'b0);
      cyc(4'b0000, 4'b0010, 1'b0);
      chk("scan_pending", pending, 4'b1001);
      cyc(4'b0000, 4'b0010, 1'b0);
      chk("scan_first", {requested_floor, dir_up, busy}, {4'b1000, 1'b1, 1'b1});
      cyc(4'b0000, 4'b0100, 1'b1);
      cyc(4'b0000, 4'b1000, 1'b1);
      chk("scan_arrive3", {arrived, pending}, {1'b1, 4'b0001});
      cyc(4'b0000, 4'b1000, 1'b1);
      cyc(4'b0000, 4'b1000, 1'b1);
      cyc(4'b0000, 4'b1000, 1'b0);
      chk("scan_reverse", {requested_floor, dir_up, busy}, {4'b0001, 1'b0, 1'b1});

      // en-route pickup at floor 2 while heading to 3
      do_reset(4'b0001);
      cyc(4'b1000, 4'b0001, 1'b0);
      cyc(4'b0000, 4'b0001, 1'b0);
      cyc(4'b0000, 4'b0001, 1'b0);
      cyc(4'b0000, 4'b0001, 1'b0);
      chk("enroute_dispatch", requested_floor, 4'b1000);
      cyc(4'b0000, 4'b0010, 1'b1);
      cyc(4'b0100, 4'b0010, 1'b0);
      cyc(4'b0000, 4'b0010, 1'b0);
      cyc(4'b0000, 4'b0010, 1'b0);
      cyc(4'b0000, 4'b0010, 1'b0);
      chk("enroute_retarget", requested_floor, 4'b0100);
      cyc(4'b0000, 4'b0100, 1'b1);
      chk("enroute_stop2", {arrived, pending}, {1'b1, 4'b1000});
      cyc(4'b0000, 4'b0100, 1'b1);
      cyc(4'b0000, 4'b0100, 1'b1);
      cyc(4'b0000, 4'b0100, 1'b0);
      chk("enroute_resume", {requested_floor, busy}, {4'b1000, 1'b1});
      cyc(4'b0000, 4'b1000, 1'b1);
      chk("enroute_stop3", {arrived, pending}, {1'b1, 4'b0000});

      // invalid position during MOVING freezes the dispatcher
      do_reset(4'b0001);
      cyc(4'b1000, 4'b0001, 1'b0);
      repeat (3) cyc(4'b0000, 4'b0001, 1'b0);
      cyc(4'b0000, 4'b0000, 1'b0);
      chk("bad_zero", {err_floor, requested_floor, pending, busy},
          {1'b1, 4'b1000, 4'b1000, 1'b1});
      cyc(4'b0010, 4'b0011, 1'b1);
      chk("bad_multi", {err_floor, requested_floor, pending, busy},
          {1'b1, 4'b1000, 4'b1000, 1'b1});
      cyc(4'b0000, 4'b0010, 1'b0);
      chk("bad_restored", {err_floor, busy}, {1'b0, 1'b1});
      repeat (4) cyc(4'b0000, 4'b0010, 1'b0);

      // asynchronous reset in the middle of a trip
      do_reset(4'b0001);
      cyc(4'b1000, 4'b0001, 1'b0);
      repeat (3) cyc(4'b0000, 4'b0001, 1'b0);
      cyc(4'b0000, 4'b0010, 1'b1);
      chk("pre_reset_moving", busy, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_reset",
          {requested_floor, pending, dir_up, busy, arrived},
          {4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0});
      model_reset();
      present_floor = 4'b0001;
      @(negedge clk);
      rst_n = 1'b1;

      // random traffic with a simple car following requested_floor
      car = 0;
      prev_arr = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         rb  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
         rtk = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 60) == 0)
            rpf = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'b0101;
         else
            rpf = 4'b0001 << car;
         cyc(rb, rpf, rtk);
         chk("arrived_gap", {prev_arr, arrived} == 2'b11, 1'b0);
         prev_arr = arrived;
         if (rtk && !err_floor) begin
            tgt = car;
            for (int i = 0; i < NF; i++) if (requested_floor[i]) tgt = i;
            if (tgt > car) car++;
            else if (tgt < car) car--;
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
